// File: rtl/pw_checker.sv
// Password store/comparator with failed-attempt counting and timed lockout.
// Optional feature macro: PW_CHECKER_LOCKOUT_EN (enables LOCKOUT state and lockout counter).
module pw_checker #(
  parameter logic [15:0] DEFAULT_PW  = 16'h1234,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [16:0] pws_in,
  input  logic [1:0]  state_in,
  output logic        pw_valid_out,
  output logic        lockout_out,
  output logic [2:0]  fail_cnt_out,
  output logic        commit_out,
  output logic        reject_out
);

`ifdef PW_CHECKER_LOCKOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, LOCKOUT = 2'd2} fsm_t;
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
  logic [LOCK_W-1:0] lock_cnt, lock_cnt_next;
`else
  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} fsm_t;
`endif

  fsm_t        state, state_next;
  logic [1:0]  state_q;
  logic [2:0]  fail_cnt, fail_cnt_next;
  logic [15:0] stored, shadow;
  logic        chg_q;
  logic        locked;
  logic        fail_ev, succ_ev;
  logic        shadow_bcd;

`ifdef PW_CHECKER_LOCKOUT_EN
  assign locked = (state == LOCKOUT);
`else
  assign locked = 1'b0;
`endif

  assign fail_ev = (state_q == 2'b01) && (state_in == 2'b00) && !locked;
  assign succ_ev = (state_q == 2'b01) && (state_in == 2'b10) && !locked;
  assign shadow_bcd = (shadow[15:12] <= 4'd9) && (shadow[11:8] <= 4'd9) &&
                      (shadow[7:4] <= 4'd9) && (shadow[3:0] <= 4'd9);

  always_comb begin
    state_next    = state;
    fail_cnt_next = fail_cnt;
`ifdef PW_CHECKER_LOCKOUT_EN
    lock_cnt_next = lock_cnt;
`endif
    case (state)
      IDLE:  if (state_in == 2'b01) state_next = ARMED;
      ARMED: if (state_in != 2'b01) state_next = IDLE;
`ifdef PW_CHECKER_LOCKOUT_EN
      LOCKOUT: begin
        // Counter is loaded with LOCK_CYCLES on entry, so exit on 1 gives exactly LOCK_CYCLES cycles.
        if (lock_cnt <= LOCK_W'(1)) begin
          state_next    = IDLE;
          fail_cnt_next = '0;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt - LOCK_W'(1);
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    if (succ_ev) begin
      fail_cnt_next = '0;
    end else if (fail_ev && (fail_cnt < 3'(MAX_FAIL))) begin
      fail_cnt_next = fail_cnt + 3'd1;
`ifdef PW_CHECKER_LOCKOUT_EN
      if (fail_cnt + 3'd1 == 3'(MAX_FAIL)) begin
        state_next    = LOCKOUT;
        lock_cnt_next = LOCK_W'(LOCK_CYCLES);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      fail_cnt <= '0;
`ifdef PW_CHECKER_LOCKOUT_EN
      lock_cnt <= '0;
`endif
    end else begin
      state    <= state_next;
      fail_cnt <= fail_cnt_next;
`ifdef PW_CHECKER_LOCKOUT_EN
      lock_cnt <= lock_cnt_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= 2'b00;
      chg_q        <= 1'b0;
      shadow       <= '0;
      stored       <= DEFAULT_PW;
      pw_valid_out <= 1'b0;
      commit_out   <= 1'b0;
      reject_out   <= 1'b0;
    end else begin
      state_q      <= state_in;
      chg_q        <= pws_in[16];
      pw_valid_out <= (pws_in[15:0] == stored) && (state_in == 2'b01) && !locked;
      commit_out   <= 1'b0;
      reject_out   <= 1'b0;
      if (pws_in[16]) shadow <= pws_in[15:0];
      if (chg_q && !pws_in[16]) begin
        if (shadow_bcd) begin
          stored     <= shadow;
          commit_out <= 1'b1;
        end else begin
          reject_out <= 1'b1;
        end
      end
    end
  end

  assign lockout_out  = locked;
  assign fail_cnt_out = fail_cnt;

endmodule

// File: tb/tb_pw_checker.sv
// Directed self-checking bench for pw_checker (MAX_FAIL=3, LOCK_CYCLES=20); adapts to PW_CHECKER_LOCKOUT_EN.
module tb_pw_checker;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [16:0] pws_in;
  logic [1:0]  state_in;
  logic        pw_valid_out, lockout_out, commit_out, reject_out;
  logic [2:0]  fail_cnt_out;
  int checks = 0;
  int failures = 0;

  pw_checker #(.DEFAULT_PW(16'h1234), .MAX_FAIL(3), .LOCK_CYCLES(20)) dut (
    .clk(clk), .reset_n(reset_n), .pws_in(pws_in), .state_in(state_in),
    .pw_valid_out(pw_valid_out), .lockout_out(lockout_out),
    .fail_cnt_out(fail_cnt_out), .commit_out(commit_out), .reject_out(reject_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; state_in = 2'b00; pws_in = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  // One attempt: enter waiting, then leave it to the given state.
  task automatic attempt(input logic [1:0] to, input logic [16:0] pw);
    state_in = 2'b01; pws_in = pw; tick();
    state_in = to; tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; state_in = 2'b01; pws_in = 17'h01234;
    tick(); tick();
    checks++;
    if ({pw_valid_out, lockout_out, commit_out, reject_out, fail_cnt_out} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000",
               {pw_valid_out, lockout_out, commit_out, reject_out, fail_cnt_out});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_compare();
    do_reset();
    state_in = 2'b01; pws_in = 17'h01234; tick();
    checks++;
    if (pw_valid_out !== 1'b1) begin failures++; $display("FAIL cmp_match got=%b exp=1", pw_valid_out); end
    pws_in = 17'h01235; tick();
    checks++;
    if (pw_valid_out !== 1'b0) begin failures++; $display("FAIL cmp_mismatch got=%b exp=0", pw_valid_out); end
    state_in = 2'b11; pws_in = 17'h01234; tick();
    checks++;
    if (pw_valid_out !== 1'b0) begin failures++; $display("FAIL cmp_not_waiting got=%b exp=0", pw_valid_out); end
  endtask

  task automatic test_commit();
    int pulses = 0;
    do_reset();
    state_in = 2'b11; pws_in = 17'h15678;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (commit_out) pulses++;
    end
    pws_in = 17'h00000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (commit_out) pulses++;
      if (i == 0) begin
        checks++;
        if (commit_out !== 1'b1) begin failures++; $display("FAIL commit_timing got=%b exp=1", commit_out); end
      end
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL commit_pulses got=%0d exp=1", pulses); end
    state_in = 2'b01; pws_in = 17'h05678; tick();
    checks++;
    if (pw_valid_out !== 1'b1) begin failures++; $display("FAIL commit_new_pw got=%b exp=1", pw_valid_out); end
    pws_in = 17'h01234; tick();
    checks++;
    if (pw_valid_out !== 1'b0) begin failures++; $display("FAIL commit_old_pw got=%b exp=0", pw_valid_out); end
    state_in = 2'b11; tick();
  endtask

  task automatic test_reject();
    do_reset();
    state_in = 2'b11; pws_in = 17'h1A234; tick(); tick();
    pws_in = 17'h00000; tick();
    checks++;
    if ({reject_out, commit_out} !== 2'b10) begin
      failures++; $display("FAIL reject_pulse got=%b exp=10", {reject_out, commit_out});
    end
    tick();
    checks++;
    if (reject_out !== 1'b0) begin failures++; $display("FAIL reject_width got=%b exp=0", reject_out); end
    state_in = 2'b01; pws_in = 17'h01234; tick();
    checks++;
    if (pw_valid_out !== 1'b1) begin failures++; $display("FAIL reject_keeps_pw got=%b exp=1", pw_valid_out); end
    state_in = 2'b11; tick();
  endtask

  task automatic test_bcd_boundary();
    do_reset();
    state_in = 2'b11; pws_in = 17'h19999; tick();
    pws_in = 17'h00000; tick();
    checks++;
    if ({commit_out, reject_out} !== 2'b10) begin
      failures++; $display("FAIL bcd_nine_commit got=%b exp=10", {commit_out, reject_out});
    end
    state_in = 2'b01; pws_in = 17'h09999; tick();
    checks++;
    if (pw_valid_out !== 1'b1) begin failures++; $display("FAIL bcd_nine_valid got=%b exp=1", pw_valid_out); end
    state_in = 2'b11; tick();
  endtask

  task automatic test_success_clear();
    do_reset();
    attempt(2'b00, 17'h00000);
    attempt(2'b00, 17'h00000);
    checks++;
    if (fail_cnt_out !== 3'd2) begin failures++; $display("FAIL succ_pre_cnt got=%0d exp=2", fail_cnt_out); end
    attempt(2'b10, 17'h01234);
    checks++;
    if (fail_cnt_out !== 3'd0) begin failures++; $display("FAIL succ_clear got=%0d exp=0", fail_cnt_out); end
    state_in = 2'b11; tick();
  endtask

`ifdef PW_CHECKER_LOCKOUT_EN
  task automatic test_lockout();
    int bad = 0;
    do_reset();
    for (int n = 1; n <= 3; n++) begin
      attempt(2'b00, 17'h00000);
      checks++;
      if (fail_cnt_out !== 3'(n)) begin failures++; $display("FAIL lock_step%0d got=%0d exp=%0d", n, fail_cnt_out, n); end
      checks++;
      if (lockout_out !== (n == 3)) begin
        failures++; $display("FAIL lock_rise%0d got=%b exp=%b", n, lockout_out, (n == 3));
      end
    end
    for (int i = 1; i <= 19; i++) begin
      state_in = (i == 10) ? 2'b00 : 2'b01;
      pws_in = 17'h01234;
      tick();
      if (lockout_out !== 1'b1 || pw_valid_out !== 1'b0 || fail_cnt_out !== 3'd3) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL lock_hold bad_cycles=%0d exp=0", bad); end
    tick();
    checks++;
    if ({lockout_out, fail_cnt_out} !== 4'b0000) begin
      failures++; $display("FAIL lock_expire got=%b exp=0000", {lockout_out, fail_cnt_out});
    end
    tick();
    checks++;
    if (pw_valid_out !== 1'b1) begin failures++; $display("FAIL lock_after_valid got=%b exp=1", pw_valid_out); end
    state_in = 2'b11; tick();
  endtask

  task automatic test_reset_mid_lockout();
    do_reset();
    state_in = 2'b11; pws_in = 17'h15678; tick();
    pws_in = 17'h00000; tick();
    for (int n = 0; n < 3; n++) attempt(2'b00, 17'h00000);
    tick(); tick();
    checks++;
    if (lockout_out !== 1'b1) begin failures++; $display("FAIL rst_lock_pre got=%b exp=1", lockout_out); end
    reset_n = 1'b0; tick();
    checks++;
    if ({lockout_out, fail_cnt_out} !== 4'b0000) begin
      failures++; $display("FAIL rst_lock_clear got=%b exp=0000", {lockout_out, fail_cnt_out});
    end
    reset_n = 1'b1; state_in = 2'b01; pws_in = 17'h01234; tick();
    checks++;
    if (pw_valid_out !== 1'b1) begin failures++; $display("FAIL rst_lock_default_pw got=%b exp=1", pw_valid_out); end
    state_in = 2'b11; tick();
  endtask
`else
  task automatic test_no_lockout();
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      attempt(2'b00, 17'h00000);
      checks++;
      if (fail_cnt_out !== 3'((n > 3) ? 3 : n)) begin
        failures++; $display("FAIL nolock_cnt%0d got=%0d exp=%0d", n, fail_cnt_out, (n > 3) ? 3 : n);
      end
      checks++;
      if (lockout_out !== 1'b0) begin failures++; $display("FAIL nolock_flag%0d got=%b exp=0", n, lockout_out); end
    end
    state_in = 2'b01; pws_in = 17'h01234; tick();
    checks++;
    if (pw_valid_out !== 1'b1) begin failures++; $display("FAIL nolock_valid got=%b exp=1", pw_valid_out); end
    state_in = 2'b11; tick();
  endtask
`endif

  task automatic test_reset_mid_change();
    do_reset();
    state_in = 2'b11; pws_in = 17'h15678; tick();
    reset_n = 1'b0; pws_in = 17'h00000; tick();
    checks++;
    if (commit_out !== 1'b0) begin failures++; $display("FAIL rst_chg_in_reset got=%b exp=0", commit_out); end
    reset_n = 1'b1; tick();
    checks++;
    if (commit_out !== 1'b0) begin failures++; $display("FAIL rst_chg_dropped got=%b exp=0", commit_out); end
    state_in = 2'b01; pws_in = 17'h01234; tick();
    checks++;
    if (pw_valid_out !== 1'b1) begin failures++; $display("FAIL rst_chg_default_pw got=%b exp=1", pw_valid_out); end
    state_in = 2'b11; tick();
  endtask

  initial begin
    reset_n = 1'b0; state_in = 2'b00; pws_in = '0;
    test_reset();
    test_compare();
    test_commit();
    test_reject();
    test_bcd_boundary();
    test_success_clear();
`ifdef PW_CHECKER_LOCKOUT_EN
    test_lockout();
    test_reset_mid_lockout();
`else
    test_no_lockout();
`endif
    test_reset_mid_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
